// File: rtl/alu_result_bcd.sv
// Sequential 14-bit binary to 4-digit packed BCD converter (double-dabble) with valid/ready on both sides.
// Optional leading-zero blank mask output enabled by defining BCD_BLANK_EN.
module alu_result_bcd #(
  parameter int unsigned IN_W    = 14,
  parameter int unsigned MAX_VAL = 9999
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0]     bcd,
  output logic            ovf
`ifdef BCD_BLANK_EN
  ,
  output logic [3:0]      blank
`endif
);

  localparam int unsigned BCD_W = 16;
  localparam int unsigned DIG_N = 4;
  localparam int unsigned CNT_W = $clog2(IN_W + 1);
  localparam logic [IN_W-1:0]  MAX_V    = IN_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_d;
  logic [IN_W-1:0]    sh, sh_d;
  logic [BCD_W-1:0]   acc, acc_d, acc_adj;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               ovf_pend, ovf_pend_d;
  logic [BCD_W-1:0]   bcd_d;
  logic               ovf_d, out_valid_d, in_ready_d;

  // Add-3 correction for every digit that would overflow past 9 when doubled
  always_comb begin
    for (int i = 0; i < int'(DIG_N); i++) begin
      acc_adj[4*i +: 4] = (acc[4*i +: 4] >= 4'd5) ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
    end
  end

  // Next-state and next-output logic; everything lands in registers below
  always_comb begin
    state_d     = state;
    sh_d        = sh;
    acc_d       = acc;
    cnt_d       = cnt;
    ovf_pend_d  = ovf_pend;
    bcd_d       = bcd;
    ovf_d       = ovf;
    out_valid_d = out_valid;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_d    = SHIFT;
          sh_d       = in_data;
          acc_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = (in_data > MAX_V);
        end
      end
      SHIFT: begin
        // Out-of-range values skip the shift engine and saturate one cycle after accept
        if (ovf_pend) begin
          ovf_pend_d  = 1'b0;
          bcd_d       = 16'h9999;
          ovf_d       = 1'b1;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          acc_d = (acc_adj << 1) | BCD_W'(sh[IN_W-1]);
          sh_d  = sh << 1;
          cnt_d = cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            bcd_d       = acc_d;
            ovf_d       = 1'b0;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sh        <= '0;
      acc       <= '0;
      cnt       <= '0;
      ovf_pend  <= 1'b0;
      bcd       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= state_d;
      sh        <= sh_d;
      acc       <= acc_d;
      cnt       <= cnt_d;
      ovf_pend  <= ovf_pend_d;
      bcd       <= bcd_d;
      ovf       <= ovf_d;
      out_valid <= out_valid_d;
      in_ready  <= in_ready_d;
    end
  end

`ifdef BCD_BLANK_EN
  logic bcd_load;

  // Leading zeros blank left to right; the ones digit always shows
  function automatic logic [3:0] blank_of(input logic [15:0] v);
    logic [3:0] b;
    b[3] = (v[15:12] == 4'd0);
    b[2] = b[3] & (v[11:8] == 4'd0);
    b[1] = b[2] & (v[7:4] == 4'd0);
    b[0] = 1'b0;
    return b;
  endfunction

  assign bcd_load = (state == SHIFT) && (ovf_pend || (cnt == LAST_CNT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank <= 4'b1110;
    end else if (bcd_load) begin
      blank <= blank_of(bcd_d);
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_bcd.sv
// Directed self-checking bench for alu_result_bcd: latency, handshake, boundaries, mid-conversion reset.
module tb_alu_result_bcd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] bcd;
  logic        ovf;
`ifdef BCD_BLANK_EN
  logic [3:0]  blank;
`endif

  int total = 0;
  int bad   = 0;

  alu_result_bcd dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd       (bcd),
    .ovf       (ovf)
`ifdef BCD_BLANK_EN
    ,
    .blank     (blank)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_blank(input string tag, input logic [3:0] exp);
`ifdef BCD_BLANK_EN
    check(tag, 32'(blank), 32'(exp));
`else
    if (exp === 4'bxxxx) check(tag, 32'(exp), 32'(exp));
`endif
  endtask

  // Offer one value in IDLE; returns at the falling edge after the accept edge
  task automatic send(input string tag, input logic [13:0] v);
    @(negedge clk);
    check({tag, ".rdy"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = v;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check({tag, ".busy"}, 32'(in_ready), 32'd0);
  endtask

  // Wait for result, check it, optionally stall for hold cycles, then consume
  task automatic wait_done(input string tag, input int lat, input logic [15:0] eb,
                           input logic eo, input logic [3:0] ebl, input int hold);
    int k = 0;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, ".lat"}, 32'(k), 32'(lat));
    check({tag, ".bcd"}, 32'(bcd), 32'(eb));
    check({tag, ".ovf"}, 32'(ovf), 32'(eo));
    check_blank({tag, ".blank"}, ebl);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".hold_v"}, 32'(out_valid), 32'd1);
      check({tag, ".hold_d"}, 32'(bcd), 32'(eb));
    end
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, ".consumed"}, 32'(out_valid), 32'd0);
    check({tag, ".rdy_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.bcd", 32'(bcd), 32'h0);
    check("rst.ovf", 32'(ovf), 32'd0);
    check_blank("rst.blank", 4'b1110);
    rst_n = 1'b1;

    send("v3", 14'd3);
    wait_done("v3", 14, 16'h0003, 1'b0, 4'b1110, 0);

    out_ready = 1'b0;
    send("v7742", 14'd7742);
    wait_done("v7742", 14, 16'h7742, 1'b0, 4'b0000, 5);

    send("v9999", 14'd9999);
    wait_done("v9999", 14, 16'h9999, 1'b0, 4'b0000, 0);

    send("v10000", 14'd10000);
    wait_done("v10000", 1, 16'h9999, 1'b1, 4'b0000, 0);

    send("v16383", 14'd16383);
    wait_done("v16383", 1, 16'h9999, 1'b1, 4'b0000, 0);

    send("v0", 14'd0);
    wait_done("v0", 14, 16'h0000, 1'b0, 4'b1110, 0);

    send("v12000", 14'd12000);
    wait_done("v12000", 1, 16'h9999, 1'b1, 4'b0000, 0);

    // Second value offered mid-conversion must wait for the first to drain
    send("v2", 14'd2);
    repeat (3) @(negedge clk);
    in_valid = 1'b1;
    in_data  = 14'd729;
    check("v2.ignored", 32'(in_ready), 32'd0);
    wait_done("v2", 11, 16'h0002, 1'b0, 4'b1110, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("v729.busy", 32'(in_ready), 32'd0);
    wait_done("v729", 14, 16'h0729, 1'b0, 4'b1000, 0);

    // Abort at shift 7
    send("abort", 14'd7742);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.in_ready", 32'(in_ready), 32'd1);
    check("abort.out_valid", 32'(out_valid), 32'd0);
    check("abort.bcd", 32'(bcd), 32'h0);
    check("abort.ovf", 32'(ovf), 32'd0);
    check_blank("abort.blank", 4'b1110);
    @(negedge clk);
    rst_n = 1'b1;
    send("v5", 14'd5);
    wait_done("v5", 14, 16'h0005, 1'b0, 4'b1110, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
